// File: rtl/cpu_pipe_pkg.sv
// Shared types and defaults for the CPU pipeline sequencing logic.
// Covers the hazard controller FSM states and the register-index type.
package cpu_pipe_pkg;

  localparam int WB_DEPTH_DEF     = 3;
  localparam int CTRL_TIMEOUT_DEF = 15;
  localparam int NREG_DEF         = 32;
  localparam int REG_W            = $clog2(NREG_DEF);

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DSTALL    = 2'd1,
    ST_CTRL_WAIT = 2'd2,
    ST_FLUSH     = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the ID stage and the hazard controller.
// The master is the pipeline (ID fields, PC-update, memory stall); the slave is the controller.
interface pipe_hazard_ctrl_if import cpu_pipe_pkg::*; ();

  logic     id_valid;
  reg_idx_t id_rs1;
  reg_idx_t id_rs2;
  logic     id_rs1_used;
  logic     id_rs2_used;
  reg_idx_t id_rd;
  logic     id_reg_write;
  logic     id_ctrl;
  logic     pc_update;
  logic     mem_busy;

  logic     pc_stall;
  logic     ifid_stall;
  logic     idex_bubble;
  logic     ifid_flush;
  logic     ctrl_pending;
  logic     ctrl_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_ctrl, pc_update, mem_busy,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, ctrl_pending, ctrl_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_ctrl, pc_update, mem_busy,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, ctrl_pending, ctrl_err
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register countdown scoreboard: a register stays busy until its in-flight
// write has reached writeback. Two read ports serve the ID source operands.
module reg_scoreboard #(
  parameter int WB_DEPTH = 3,
  parameter int NREG     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    load_en,
  input  logic [$clog2(NREG)-1:0] load_idx,
  input  logic [$clog2(NREG)-1:0] rd_idx_a,
  input  logic [$clog2(NREG)-1:0] rd_idx_b,
  output logic                    busy_a,
  output logic                    busy_b
);

  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int IW = $clog2(NREG);

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] busy_vec;

  // NOTE: the counters are reset even though they form a register array; stale
  // non-zero values would raise phantom hazards straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else if (!hold) begin
      for (int i = 0; i < NREG; i++) begin
        // Register 0 is hardwired, so it is never loaded and never busy.
        if (load_en && load_idx == IW'(i) && i != 0) cnt[i] <= CW'(WB_DEPTH);
        else if (cnt[i] != '0)                      cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) busy_vec[i] = (cnt[i] != '0);
  end

  assign busy_a = busy_vec[rd_idx_a];
  assign busy_b = busy_vec[rd_idx_b];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side sequencing controller: stalls ID on RAW hazards, freezes fetch
// around call/ret/branch until the PC-update logic reports, then flushes IF/ID.
module pipe_hazard_ctrl import cpu_pipe_pkg::*; #(
  parameter int WB_DEPTH     = WB_DEPTH_DEF,
  parameter int CTRL_TIMEOUT = CTRL_TIMEOUT_DEF,
  parameter int NREG         = NREG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int TW = $clog2(CTRL_TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          err_q;
  logic          upd_pend;

  logic busy_rs1;
  logic busy_rs2;
  logic hz;
  logic run_like;
  logic issue;
  logic load_en;

  assign hz = bus.id_valid &
              ((bus.id_rs1_used & busy_rs1) | (bus.id_rs2_used & busy_rs2));

  // The cycle DSTALL sees its hazard clear behaves exactly like RUN.
  assign run_like = (state == ST_RUN) || (state == ST_DSTALL);
  assign issue    = run_like & bus.id_valid & ~hz & ~bus.mem_busy;
  assign load_en  = issue & bus.id_reg_write & (bus.id_rd != REG_ZERO);

  reg_scoreboard #(
    .WB_DEPTH (WB_DEPTH),
    .NREG     (NREG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .hold     (bus.mem_busy),
    .load_en  (load_en),
    .load_idx (bus.id_rd),
    .rd_idx_a (bus.id_rs1),
    .rd_idx_b (bus.id_rs2),
    .busy_a   (busy_rs1),
    .busy_b   (busy_rs2)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      timer    <= '0;
      err_q    <= 1'b0;
      upd_pend <= 1'b0;
    end else if (bus.mem_busy) begin
      // Frozen pipeline: remember a PC-update so it is not lost.
      if (state == ST_CTRL_WAIT && bus.pc_update) upd_pend <= 1'b1;
    end else begin
      case (state)
        ST_RUN, ST_DSTALL: begin
          if (hz) begin
            state <= ST_DSTALL;
          end else if (issue && bus.id_ctrl) begin
            state <= ST_CTRL_WAIT;
            timer <= '0;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_CTRL_WAIT: begin
          timer    <= timer + TW'(1);
          upd_pend <= 1'b0;
          if (bus.pc_update || upd_pend) begin
            state <= ST_FLUSH;
          end else if (timer == TW'(CTRL_TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.pc_stall    = 1'b0;
    bus.ifid_stall  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.ifid_flush  = 1'b0;
    if (bus.mem_busy) begin
      bus.pc_stall   = 1'b1;
      bus.ifid_stall = 1'b1;
    end else begin
      case (state)
        ST_RUN, ST_DSTALL: begin
          bus.pc_stall    = hz;
          bus.ifid_stall  = hz;
          bus.idex_bubble = hz;
        end
        ST_CTRL_WAIT: begin
          bus.pc_stall    = 1'b1;
          bus.ifid_stall  = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        ST_FLUSH: bus.ifid_flush = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ctrl_pending = (state == ST_CTRL_WAIT) || (state == ST_FLUSH);
  assign bus.ctrl_err     = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expected outputs are queued
// as stimulus is applied and compared against the DUT at the falling edge.
module tb_pipe_hazard_ctrl;
  import cpu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .WB_DEPTH     (3),
    .CTRL_TIMEOUT (15),
    .NREG         (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Output vector: {pc_stall, ifid_stall, idex_bubble, ifid_flush, ctrl_pending, ctrl_err}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_HZ   = 6'b111000;
  localparam logic [5:0] O_CW   = 6'b111010;
  localparam logic [5:0] O_FL   = 6'b000110;
  localparam logic [5:0] O_MB   = 6'b110000;
  localparam logic [5:0] O_ERR  = 6'b000001;

  typedef struct {
    string       tag;
    logic [5:0]  outs;
    bit          chk_st;
    logic [1:0]  st;
    bit          chk_sb;
    logic [31:0] sb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, " outs"},
            32'({bus.pc_stall, bus.ifid_stall, bus.idex_bubble,
                 bus.ifid_flush, bus.ctrl_pending, bus.ctrl_err}),
            32'(e.outs));
      if (e.chk_st) check({e.tag, " state"}, 32'(dut.state), 32'(e.st));
      if (e.chk_sb) check({e.tag, " busy"}, dut.u_sb.busy_vec, e.sb);
    end
  end

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic ctl);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs1_used  = u1;
    bus.id_rs2       = rs2;
    bus.id_rs2_used  = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_ctrl      = ctl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Queue the expectation for the cycle whose inputs were just applied, then advance.
  task automatic tick(input string tag, input logic [5:0] outs, input int st = -1,
                      input bit chk_sb = 1'b0, input logic [31:0] sb = 32'h0);
    exp_t e;
    e.tag    = tag;
    e.outs   = outs;
    e.chk_st = (st >= 0);
    e.st     = 2'(st);
    e.chk_sb = chk_sb;
    e.sb     = sb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.pc_update = 1'b0;
    bus.mem_busy  = 1'b0;
    idle();
    @(posedge clk);
    #1;
    tick("reset", O_IDLE, ST_RUN, 1'b1, 32'h0);
    rst = 1'b0;

    // RAW on r5 immediately after its write: three stall cycles, issue on the fourth.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick("t1 write r5", O_IDLE, ST_RUN);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick("t1 hz detect", O_HZ, ST_RUN, 1'b1, 32'h0000_0020);
    tick("t1 dstall a", O_HZ, ST_DSTALL);
    tick("t1 dstall b", O_HZ, ST_DSTALL);
    tick("t1 exit issue", O_IDLE, ST_DSTALL);
    idle();
    tick("t1 back run", O_IDLE, ST_RUN, 1'b1, 32'h0000_0040);

    // r0 is never busy.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick("t2 write r0", O_IDLE, ST_RUN, 1'b1, 32'h0000_0040);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    tick("t2 read r0", O_IDLE, ST_RUN, 1'b1, 32'h0000_0040);
    idle();
    tick("t2 sb clear", O_IDLE, ST_RUN, 1'b1, 32'h0);

    // Branch: four wait cycles, pc_update on the fourth, one flush cycle.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick("t3 branch issue", O_IDLE, ST_RUN);
    idle();
    for (int i = 0; i < 3; i++) tick("t3 ctrl wait", O_CW, ST_CTRL_WAIT);
    bus.pc_update = 1'b1;
    tick("t3 pc update", O_CW, ST_CTRL_WAIT);
    bus.pc_update = 1'b0;
    tick("t3 flush", O_FL, ST_FLUSH);
    tick("t3 run", O_IDLE, ST_RUN);
    bus.pc_update = 1'b1;
    tick("t3 stray pc_update", O_IDLE, ST_RUN);
    bus.pc_update = 1'b0;
    tick("t3 still run", O_IDLE, ST_RUN);

    // ret reading r31 twice while its counter is 2; pc_update in DSTALL is dropped.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0);
    tick("t4 write r31", O_IDLE, ST_RUN);
    idle();
    tick("t4 gap", O_IDLE, ST_RUN, 1'b1, 32'h8000_0000);
    drive(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 1'b1);
    tick("t4 ret hz", O_HZ, ST_RUN);
    bus.pc_update = 1'b1;
    tick("t4 dstall pc_update", O_HZ, ST_DSTALL);
    bus.pc_update = 1'b0;
    tick("t4 ret issue", O_IDLE, ST_DSTALL, 1'b1, 32'h0);
    idle();
    for (int i = 0; i < 15; i++) tick("t4 ctrl wait", O_CW, ST_CTRL_WAIT);
    tick("t4 timeout flush", O_FL | O_ERR, ST_FLUSH);
    tick("t4 err sticky", O_ERR, ST_RUN);

    // Call writing r7, then a 3-cycle memory stall with pc_update latched meanwhile.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick("t5 call w r7", O_ERR, ST_RUN);
    idle();
    tick("t5 ctrl wait", O_CW | O_ERR, ST_CTRL_WAIT, 1'b1, 32'h0000_0080);
    bus.mem_busy  = 1'b1;
    bus.pc_update = 1'b1;
    tick("t5 busy pc_update", O_MB | 6'b000011, ST_CTRL_WAIT, 1'b1, 32'h0000_0080);
    bus.pc_update = 1'b0;
    tick("t5 busy hold a", O_MB | 6'b000011, ST_CTRL_WAIT, 1'b1, 32'h0000_0080);
    tick("t5 busy hold b", O_MB | 6'b000011, ST_CTRL_WAIT, 1'b1, 32'h0000_0080);
    bus.mem_busy = 1'b0;
    tick("t5 resume", O_CW | O_ERR, ST_CTRL_WAIT, 1'b1, 32'h0000_0080);
    tick("t5 flush", O_FL | O_ERR, ST_FLUSH, 1'b1, 32'h0000_0080);
    tick("t5 run", O_ERR, ST_RUN, 1'b1, 32'h0);

    // mem_busy masks the bubble of a pending hazard and holds the counter.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick("t5 write r9", O_ERR, ST_RUN);
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.mem_busy = 1'b1;
    tick("t5 busy masks bubble", O_MB | O_ERR, ST_RUN);

    // Reset in CTRL_WAIT with ctrl_err set and r9 still busy.
    bus.mem_busy = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick("t6 branch issue", O_ERR, ST_RUN, 1'b1, 32'h0000_0200);
    idle();
    tick("t6 ctrl wait", O_CW | O_ERR, ST_CTRL_WAIT, 1'b1, 32'h0000_0200);
    rst = 1'b1;
    tick("t6 rst in wait", O_CW | O_ERR, ST_CTRL_WAIT);
    rst = 1'b0;
    tick("t6 after rst", O_IDLE, ST_RUN, 1'b1, 32'h0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
